ravenoc_irq_reader: RTL and testbench

IRQ-driven AXI4 read master that drains received packets from one RaveNoC node. It sits downstream of the NoC AXI slave port and its per-node IRQ vector. It watches the node's per-VC IRQ bits, picks a pending VC by round-robin, and issues a fixed-length AXI read burst to that VC's RX buffer address. Returned beats are forwarded on a valid/ready stream tagged with the VC index, while the block checks response codes and burst length.

---
 rtl/ravenoc_pkg.sv | 35 +++
 rtl/ravenoc_rr_arb.sv | 38 +++
 rtl/ravenoc_irq_reader.sv | 174 +++++++++++++++++
 tb/tb_ravenoc_irq_reader.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ravenoc_pkg.sv
// ravenoc_pkg: shared AXI and NoC types for the RaveNoC IRQ reader slice.
// Provides the AXI address/size/burst/response types, the virtual channel
// count default and the state encoding of the IRQ-driven read master.
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 64
`endif

package ravenoc_pkg;

  localparam int NumVirtChn   = 32'd3;
  localparam int AxiAddrWidth = 32'd32;

  typedef logic [AxiAddrWidth-1:0] axi_addr_t;
  typedef logic [2:0]              asize_t;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } aburst_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } aerror_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10
  } irq_rd_st_t;

endpackage

// File: rtl/ravenoc_rr_arb.sv
// ravenoc_rr_arb: combinational round-robin priority selector.
// Ports:
//   req       - one request bit per channel
//   last      - index of the channel served most recently
//   gnt_idx   - granted channel index (valid only with gnt_valid)
//   gnt_valid - at least one request is pending
// The search starts at last+1 and wraps modulo N, so the channel just served
// has the lowest priority on the next pick.
module ravenoc_rr_arb #(
  parameter  int N  = 32'd3,
  localparam int IW = (N > 32'd1) ? $clog2(N) : 32'd1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid
);

  logic [IW-1:0] cand_s;

  // Walk the channels in rotated order and keep the first pending one.
  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand_s    = '0;
    for (int i = 0; i < N; i++) begin
      // Modulo keeps the candidate inside 0..N-1 even for non power-of-two N.
      cand_s = IW'((int'(last) + 32'sd1 + i) % N);
      if (!gnt_valid && req[cand_s]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand_s;
      end else begin
        gnt_valid = gnt_valid;
      end
    end
  end

endmodule

// File: rtl/ravenoc_irq_reader.sv
// ravenoc_irq_reader: IRQ-driven AXI4 read master draining one RaveNoC node.
// Picks a pending VC round-robin from the IRQ vector, issues one fixed-length
// read burst to that VC's RX buffer and forwards the beats on a valid/ready
// stream tagged with the VC index.
// Ports:
//   clk_axi, arst_axi           - clock, async active-low reset
//   enable_i, irq_vcs_i         - start permission, per-VC level IRQs
//   ar*_o / arready_i           - AXI read address channel
//   r*_i / rready_o             - AXI read data channel
//   out_*_o / out_ready_i       - beat stream (combinational pass-through)
//   err_o                       - sticky response/length error
//   pkt_cnt_o                   - completed bursts, wrapping
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 64
`endif

module ravenoc_irq_reader
  import ravenoc_pkg::*;
#(
  parameter  int        NUM_VC       = NumVirtChn,
  parameter  axi_addr_t RD_BASE_ADDR = 32'h0000_1000,
  parameter  int        VC_STRIDE    = 32'd8,
  parameter  int        BURST_LEN    = 32'd4,
  localparam int        VC_W         = (NUM_VC > 32'd1) ? $clog2(NUM_VC) : 32'd1
) (
  input  logic                       clk_axi,
  input  logic                       arst_axi,
  input  logic                       enable_i,
  input  logic [NUM_VC-1:0]          irq_vcs_i,
  output logic                       arvalid_o,
  input  logic                       arready_i,
  output axi_addr_t                  araddr_o,
  output logic [7:0]                 arlen_o,
  output asize_t                     arsize_o,
  output aburst_t                    arburst_o,
  output logic                       arid_o,
  input  logic                       rvalid_i,
  output logic                       rready_o,
  input  logic [`AXI_DATA_WIDTH-1:0] rdata_i,
  input  aerror_t                    rresp_i,
  input  logic                       rlast_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [`AXI_DATA_WIDTH-1:0] out_data_o,
  output logic [VC_W-1:0]            out_vc_o,
  output logic                       out_last_o,
  output logic                       err_o,
  output logic [15:0]                pkt_cnt_o
);

  localparam logic [7:0] LAST_CNT  = 8'(BURST_LEN - 32'd1);
  localparam asize_t     ARSIZE_C  = asize_t'($clog2(`AXI_DATA_WIDTH / 8));

  irq_rd_st_t      state_r, state_nxt_s;
  logic [VC_W-1:0] vc_r, vc_nxt_s;
  logic [VC_W-1:0] last_r, last_nxt_s;
  axi_addr_t       addr_r, addr_nxt_s;
  logic [7:0]      cnt_r, cnt_nxt_s;
  logic [15:0]     pkt_r, pkt_nxt_s;
  logic            err_r, err_nxt_s;

  logic [VC_W-1:0] gnt_idx_s;
  logic            gnt_valid_s;
  logic            in_data_s;
  logic            r_hs_s;
  logic            at_last_s;

  ravenoc_rr_arb #(
    .N (NUM_VC)
  ) u_arb (
    .req       (irq_vcs_i),
    .last      (last_r),
    .gnt_idx   (gnt_idx_s),
    .gnt_valid (gnt_valid_s)
  );

  // Next-state, burst bookkeeping and error detection.
  always_comb begin
    state_nxt_s = state_r;
    vc_nxt_s    = vc_r;
    last_nxt_s  = last_r;
    addr_nxt_s  = addr_r;
    cnt_nxt_s   = cnt_r;
    pkt_nxt_s   = pkt_r;
    err_nxt_s   = err_r;
    in_data_s   = (state_r == DATA);
    r_hs_s      = in_data_s && rvalid_i && out_ready_i;
    at_last_s   = (cnt_r == LAST_CNT);
    case (state_r)
      IDLE: begin
        if (enable_i && gnt_valid_s) begin
          state_nxt_s = ADDR;
          vc_nxt_s    = gnt_idx_s;
          addr_nxt_s  = RD_BASE_ADDR + (axi_addr_t'(gnt_idx_s) * axi_addr_t'(VC_STRIDE));
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ADDR: begin
        // AR stays up until accepted; enable/IRQ changes are ignored here.
        if (arready_i) begin
          state_nxt_s = DATA;
          cnt_nxt_s   = 8'd0;
        end else begin
          state_nxt_s = ADDR;
        end
      end
      DATA: begin
        if (r_hs_s) begin
          cnt_nxt_s = at_last_s ? cnt_r : (cnt_r + 8'd1);
          // Bad response, early last, or a missing last at the final count.
          if ((rresp_i != OKAY) || (rlast_i && !at_last_s) || (!rlast_i && at_last_s)) begin
            err_nxt_s = 1'b1;
          end else begin
            err_nxt_s = err_r;
          end
          // The burst only ends on rlast, even when it arrives late.
          if (rlast_i) begin
            state_nxt_s = IDLE;
            pkt_nxt_s   = pkt_r + 16'd1;
            last_nxt_s  = vc_r;
          end else begin
            state_nxt_s = DATA;
          end
        end else begin
          state_nxt_s = DATA;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and bookkeeping registers; the pointer resets to NUM_VC-1 so the
  // first search begins at VC0.
  always_ff @(posedge clk_axi or negedge arst_axi) begin
    if (!arst_axi) begin
      state_r <= IDLE;
      vc_r    <= '0;
      last_r  <= VC_W'(NUM_VC - 32'd1);
      addr_r  <= RD_BASE_ADDR;
      cnt_r   <= 8'd0;
      pkt_r   <= 16'd0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      vc_r    <= vc_nxt_s;
      last_r  <= last_nxt_s;
      addr_r  <= addr_nxt_s;
      cnt_r   <= cnt_nxt_s;
      pkt_r   <= pkt_nxt_s;
      err_r   <= err_nxt_s;
    end
  end

  // Output decode; the R-to-stream path is zero-latency and gated to DATA.
  always_comb begin
    arvalid_o   = (state_r == ADDR);
    araddr_o    = addr_r;
    arlen_o     = LAST_CNT;
    arsize_o    = ARSIZE_C;
    arburst_o   = FIXED;
    arid_o      = 1'b0;
    rready_o    = in_data_s && out_ready_i;
    out_valid_o = in_data_s && rvalid_i;
    out_data_o  = rdata_i;
    out_last_o  = in_data_s && rlast_i;
    out_vc_o    = vc_r;
    err_o       = err_r;
    pkt_cnt_o   = pkt_r;
  end

endmodule

// File: tb/tb_ravenoc_irq_reader.sv
// tb_ravenoc_irq_reader: directed self-checking bench for ravenoc_irq_reader.
// Acts as the AXI slave and the stream sink; expected values are hand-derived
// constants plus a tiny error/packet-count model.
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 64
`endif

module tb_ravenoc_irq_reader;
  import ravenoc_pkg::*;

  localparam int BL = 4;

  logic                       clk_axi;
  logic                       arst_axi;
  logic                       enable_i;
  logic [2:0]                 irq_vcs_i;
  logic                       arvalid_o;
  logic                       arready_i;
  axi_addr_t                  araddr_o;
  logic [7:0]                 arlen_o;
  asize_t                     arsize_o;
  aburst_t                    arburst_o;
  logic                       arid_o;
  logic                       rvalid_i;
  logic                       rready_o;
  logic [`AXI_DATA_WIDTH-1:0] rdata_i;
  aerror_t                    rresp_i;
  logic                       rlast_i;
  logic                       out_valid_o;
  logic                       out_ready_i;
  logic [`AXI_DATA_WIDTH-1:0] out_data_o;
  logic [1:0]                 out_vc_o;
  logic                       out_last_o;
  logic                       err_o;
  logic [15:0]                pkt_cnt_o;

  int          n_total = 0;
  int          n_bad   = 0;
  logic        err_model;
  logic [15:0] pkt_model;

  ravenoc_irq_reader #(
    .NUM_VC       (3),
    .RD_BASE_ADDR (32'h0000_1000),
    .VC_STRIDE    (8),
    .BURST_LEN    (BL)
  ) dut (
    .clk_axi     (clk_axi),
    .arst_axi    (arst_axi),
    .enable_i    (enable_i),
    .irq_vcs_i   (irq_vcs_i),
    .arvalid_o   (arvalid_o),
    .arready_i   (arready_i),
    .araddr_o    (araddr_o),
    .arlen_o     (arlen_o),
    .arsize_o    (arsize_o),
    .arburst_o   (arburst_o),
    .arid_o      (arid_o),
    .rvalid_i    (rvalid_i),
    .rready_o    (rready_o),
    .rdata_i     (rdata_i),
    .rresp_i     (rresp_i),
    .rlast_i     (rlast_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_vc_o    (out_vc_o),
    .out_last_o  (out_last_o),
    .err_o       (err_o),
    .pkt_cnt_o   (pkt_cnt_o)
  );

  initial clk_axi = 1'b0;
  always #5 clk_axi = ~clk_axi;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk_axi); #1;
    arst_axi    = 1'b0;
    enable_i    = 1'b0;
    irq_vcs_i   = 3'b000;
    arready_i   = 1'b0;
    rvalid_i    = 1'b0;
    rlast_i     = 1'b0;
    rresp_i     = OKAY;
    out_ready_i = 1'b1;
    repeat (2) @(posedge clk_axi);
    #1 arst_axi = 1'b1;
    err_model = 1'b0;
    pkt_model = 16'd0;
  endtask

  // Waits for AR, checks address/hold, then accepts it; ends in DATA at posedge+1.
  task automatic ar_phase(input logic [1:0] vc, input int stall, output int waited);
    logic [63:0] exp_addr;
    exp_addr = 64'h1000 + 64'(vc) * 64'h8;
    waited = 0;
    @(negedge clk_axi);
    while (!arvalid_o && waited < 20) begin
      @(negedge clk_axi);
      waited++;
    end
    check_val("ar_valid", 64'(arvalid_o), 64'd1);
    check_val("ar_addr", 64'(araddr_o), exp_addr);
    check_val("ar_rready_low", 64'(rready_o), 64'd0);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk_axi); #1;
      @(negedge clk_axi);
      check_val("ar_hold_valid", 64'(arvalid_o), 64'd1);
      check_val("ar_hold_addr", 64'(araddr_o), exp_addr);
    end
    @(posedge clk_axi); #1 arready_i = 1'b1;
    @(posedge clk_axi); #1 arready_i = 1'b0;
  endtask

  // Serves nbeats beats (rlast on the final one); ends at the negedge of the
  // cycle after the rlast handshake.
  task automatic r_phase(input int nbeats, input int bad_beat, input logic [7:0] rdy_pat,
                         input int pat_len, input logic [1:0] vc, input int drop_en_beat);
    int          b   = 1;
    int          cyc = 0;
    int          acc = 0;
    int          cnt;
    logic [63:0] exp_data;
    while (b <= nbeats && cyc < 40) begin
      exp_data    = 64'hA5A5_0000_0000_0000 | (64'(vc) << 8) | 64'(b);
      rvalid_i    = 1'b1;
      rdata_i     = exp_data;
      rlast_i     = (b == nbeats);
      rresp_i     = (b == bad_beat) ? SLVERR : OKAY;
      out_ready_i = (cyc < pat_len) ? rdy_pat[cyc] : 1'b1;
      if (b == drop_en_beat) enable_i = 1'b0;
      @(negedge clk_axi);
      check_val("out_valid", 64'(out_valid_o), 64'd1);
      check_val("out_data", out_data_o, exp_data);
      check_val("out_last", 64'(out_last_o), 64'(b == nbeats));
      check_val("rready_mirror", 64'(rready_o), 64'(out_ready_i));
      check_val("out_vc", 64'(out_vc_o), 64'(vc));
      check_val("err_track", 64'(err_o), 64'(err_model));
      if (out_ready_i) begin
        cnt = (b - 1 > BL - 1) ? BL - 1 : b - 1;
        if ((b == bad_beat) || ((b == nbeats) && cnt != BL - 1) ||
            ((b != nbeats) && cnt == BL - 1)) err_model = 1'b1;
        if (b == nbeats) pkt_model = pkt_model + 16'd1;
        acc++;
        b++;
      end
      cyc++;
      @(posedge clk_axi); #1;
    end
    rvalid_i    = 1'b0;
    rlast_i     = 1'b0;
    rresp_i     = OKAY;
    out_ready_i = 1'b1;
    check_val("beats_accepted", 64'(acc), 64'(nbeats));
    @(negedge clk_axi);
    check_val("idle_out_valid", 64'(out_valid_o), 64'd0);
    check_val("idle_arvalid", 64'(arvalid_o), 64'd0);
    check_val("pkt_cnt", 64'(pkt_cnt_o), 64'(pkt_model));
    check_val("err_end", 64'(err_o), 64'(err_model));
  endtask

  initial begin
    int   w;
    logic seen_ar;
    arst_axi    = 1'b0;
    enable_i    = 1'b0;
    irq_vcs_i   = 3'b000;
    arready_i   = 1'b0;
    rvalid_i    = 1'b0;
    rdata_i     = '0;
    rresp_i     = OKAY;
    rlast_i     = 1'b0;
    out_ready_i = 1'b1;
    err_model   = 1'b0;
    pkt_model   = 16'd0;

    // Reset values.
    repeat (3) @(posedge clk_axi);
    @(negedge clk_axi);
    check_val("rst_arvalid", 64'(arvalid_o), 64'd0);
    check_val("rst_rready", 64'(rready_o), 64'd0);
    check_val("rst_out_valid", 64'(out_valid_o), 64'd0);
    check_val("rst_out_last", 64'(out_last_o), 64'd0);
    check_val("rst_err", 64'(err_o), 64'd0);
    check_val("rst_pkt", 64'(pkt_cnt_o), 64'd0);
    check_val("rst_out_vc", 64'(out_vc_o), 64'd0);
    check_val("rst_araddr", 64'(araddr_o), 64'h1000);
    check_val("arlen", 64'(arlen_o), 64'd3);
    check_val("arsize", 64'(arsize_o), 64'd3);
    check_val("arburst", 64'(arburst_o), 64'd0);
    check_val("arid", 64'(arid_o), 64'd0);
    @(posedge clk_axi); #1 arst_axi = 1'b1;

    // Single-VC read on VC1.
    @(posedge clk_axi); #1;
    enable_i  = 1'b1;
    irq_vcs_i = 3'b010;
    ar_phase(2'd1, 0, w);
    check_val("ar_latency", 64'(w), 64'd1);
    irq_vcs_i = 3'b000;
    r_phase(4, 0, 8'h00, 0, 2'd1, 0);

    // Round-robin from reset with all IRQs held: VC0, VC1, VC2, VC0.
    do_reset();
    enable_i  = 1'b1;
    irq_vcs_i = 3'b111;
    for (int k = 0; k < 4; k++) begin
      ar_phase(2'(k % 3), 0, w);
      check_val("rr_turnaround", 64'(w), (k == 0) ? 64'd1 : 64'd0);
      if (k == 3) irq_vcs_i = 3'b000;
      r_phase(4, 0, 8'h00, 0, 2'(k % 3), 0);
    end

    // Backpressure: AR stalled 5 cycles, stream ready 1,0,0,1.
    @(posedge clk_axi); #1 irq_vcs_i = 3'b001;
    ar_phase(2'd0, 5, w);
    irq_vcs_i = 3'b000;
    r_phase(4, 0, 8'b0000_1001, 4, 2'd0, 0);

    // SLVERR on beat 2 of a VC2 burst.
    @(posedge clk_axi); #1 irq_vcs_i = 3'b100;
    ar_phase(2'd2, 0, w);
    irq_vcs_i = 3'b000;
    r_phase(4, 2, 8'h00, 0, 2'd2, 0);
    check_val("slverr_sticky", 64'(err_o), 64'd1);

    // Early last on beat 3.
    do_reset();
    enable_i  = 1'b1;
    irq_vcs_i = 3'b001;
    ar_phase(2'd0, 0, w);
    irq_vcs_i = 3'b000;
    r_phase(3, 0, 8'h00, 0, 2'd0, 0);
    check_val("early_last_err", 64'(err_o), 64'd1);

    // Late last on beat 5.
    do_reset();
    enable_i  = 1'b1;
    irq_vcs_i = 3'b001;
    ar_phase(2'd0, 0, w);
    irq_vcs_i = 3'b000;
    r_phase(5, 0, 8'h00, 0, 2'd0, 0);
    check_val("late_last_err", 64'(err_o), 64'd1);

    // Drop enable mid-burst: burst completes, no new AR despite IRQ.
    @(posedge clk_axi); #1 irq_vcs_i = 3'b010;
    ar_phase(2'd1, 0, w);
    r_phase(4, 0, 8'h00, 0, 2'd1, 2);
    seen_ar = 1'b0;
    repeat (6) begin
      @(negedge clk_axi);
      if (arvalid_o) seen_ar = 1'b1;
    end
    check_val("disable_no_ar", 64'(seen_ar), 64'd0);

    // Reset mid-DATA after one beat.
    @(posedge clk_axi); #1 enable_i = 1'b1;
    ar_phase(2'd1, 0, w);
    check_val("ar_latency_2", 64'(w), 64'd1);
    rvalid_i = 1'b1;
    rdata_i  = 64'h1234;
    rlast_i  = 1'b0;
    @(negedge clk_axi);
    check_val("mid_beat_valid", 64'(out_valid_o), 64'd1);
    @(posedge clk_axi); #1;
    rlast_i  = 1'b1;
    arst_axi = 1'b0;
    #1;
    check_val("mrst_arvalid", 64'(arvalid_o), 64'd0);
    check_val("mrst_rready", 64'(rready_o), 64'd0);
    check_val("mrst_out_valid", 64'(out_valid_o), 64'd0);
    check_val("mrst_out_last", 64'(out_last_o), 64'd0);
    check_val("mrst_err", 64'(err_o), 64'd0);
    check_val("mrst_pkt", 64'(pkt_cnt_o), 64'd0);
    check_val("mrst_out_vc", 64'(out_vc_o), 64'd0);
    check_val("mrst_araddr", 64'(araddr_o), 64'h1000);
    err_model = 1'b0;
    pkt_model = 16'd0;
    @(posedge clk_axi); #1;
    arst_axi  = 1'b1;
    rvalid_i  = 1'b0;
    rlast_i   = 1'b0;
    irq_vcs_i = 3'b111;
    ar_phase(2'd0, 0, w);
    check_val("ptr_reset_latency", 64'(w), 64'd1);
    irq_vcs_i = 3'b000;
    r_phase(4, 0, 8'h00, 0, 2'd0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
